// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stalls, redirect flushes, memory-wait holds
// with a timeout halt, plus saturating stall/flush event counters.
module hazard_controller #(
    parameter int WAIT_LIMIT = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [4:0]  ID_RegisterRs,
    input  logic [4:0]  ID_RegisterRt,
    input  logic        ID_UsesRt,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_RegisterRt,
    input  logic        EX_Redirect,
    input  logic        MEM_Access,
    input  logic        MEM_Ready,
    input  logic        clear_counters,
    output logic        PC_Write,
    output logic        IF_ID_Write,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Flush,
    output logic        PipeHold,
    output logic        MEM_WB_Flush,
    output logic        Timeout,
    output logic [1:0]  State,
    output logic [15:0] StallCount,
    output logic [15:0] FlushCount
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        HALT     = 2'b10
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(WAIT_LIMIT - 1);

    state_t     state, state_next;
    logic [7:0] wait_cnt, wait_cnt_next;
    logic       mem_wait, load_use;
    logic       count_flush, count_stall;

    assign mem_wait = MEM_Access & ~MEM_Ready;
    assign load_use = EX_MemRead & (EX_RegisterRt != 5'd0) &
                      ((EX_RegisterRt == ID_RegisterRs) |
                       (ID_UsesRt & (EX_RegisterRt == ID_RegisterRt)));

    assign State = state;

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        PC_Write      = 1'b1;
        IF_ID_Write   = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EX_Flush   = 1'b0;
        PipeHold      = 1'b0;
        MEM_WB_Flush  = 1'b0;
        count_flush   = 1'b0;
        count_stall   = 1'b0;

        case (state)
            RUN: begin
                wait_cnt_next = 8'd0;
                if (mem_wait)
                    state_next = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (mem_wait) begin
                    wait_cnt_next = wait_cnt + 8'd1;
                    if (wait_cnt == LAST_WAIT)
                        state_next = HALT;
                end else begin
                    state_next = RUN;
                end
            end
            HALT: state_next = HALT;
            default: state_next = RUN;
        endcase

        // A memory wait masks redirects and load-use; they are counted once it clears.
        if (state == HALT) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            PipeHold    = 1'b1;
        end else if (mem_wait) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            PipeHold     = 1'b1;
            MEM_WB_Flush = 1'b1;
        end else if (EX_Redirect) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
            count_flush = 1'b1;
        end else if (load_use) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
            count_stall = 1'b1;
        end

        if (!reset_n) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            PipeHold     = 1'b0;
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            MEM_WB_Flush = 1'b1;
            count_flush  = 1'b0;
            count_stall  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= RUN;
            wait_cnt   <= 8'd0;
            Timeout    <= 1'b0;
            StallCount <= 16'd0;
            FlushCount <= 16'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (state_next == HALT)
                Timeout <= 1'b1;
            if (clear_counters) begin
                StallCount <= 16'd0;
                FlushCount <= 16'd0;
            end else begin
                if (count_stall && StallCount != 16'hFFFF)
                    StallCount <= StallCount + 16'd1;
                if (count_flush && FlushCount != 16'hFFFF)
                    FlushCount <= FlushCount + 16'd1;
            end
        end
    end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have parameter: WAIT_LIMIT, default 255, max consecutive memory-wait cycles before halt (range 1..255).
REQ-002 clock  in  1  single clock; all state updates on posedge.
REQ-003 reset_n  in  1  synchronous, active-low reset, sampled on posedge clock.
REQ-004 ID_RegisterRs  in  5  rs field of instruction in ID.
REQ-005 ID_RegisterRt  in  5  rt field of instruction in ID.
REQ-006 ID_UsesRt  in  1  ID instruction reads rt (R-type, beq, bne, sw).
REQ-007 EX_MemRead  in  1  instruction in EX is lw.
REQ-008 EX_RegisterRt  in  5  destination rt of instruction in EX.
REQ-009 EX_Redirect  in  1  branch taken or jump resolved in EX.
REQ-010 MEM_Access  in  1  instruction in MEM accesses data memory.
REQ-011 MEM_Ready  in  1  data memory completes access this cycle.
REQ-012 clear_counters  in  1  synchronous clear of both counters.
REQ-013 PC_Write  out  1  PC load enable.
REQ-014 IF_ID_Write  out  1  IF/ID register load enable.
REQ-015 IF_ID_Flush  out  1  load NOP into IF/ID.
REQ-016 ID_EX_Flush  out  1  load bubble (all controls 0) into ID/EX.
REQ-017 PipeHold  out  1  hold ID/EX and EX/MEM registers.
REQ-018 MEM_WB_Flush  out  1  load bubble into MEM/WB.
REQ-019 Timeout  out  1  sticky: memory wait exceeded WAIT_LIMIT.
REQ-020 State  out  2  FSM state: 00 RUN, 01 MEM_WAIT, 10 HALT.
REQ-021 StallCount  out  16  load-use stall cycles.
REQ-022 FlushCount  out  16  redirect flush cycles.

Function
REQ-023 Control outputs SHALL be combinational from State and current inputs (zero-cycle latency); State, wait counter, Timeout, StallCount, FlushCount SHALL be registered.
REQ-024 Conditions: wait = MEM_Access & ~MEM_Ready; load_use = EX_MemRead & (EX_RegisterRt != 0) & ((EX_RegisterRt == ID_RegisterRs) | (ID_UsesRt & EX_RegisterRt == ID_RegisterRt)).
REQ-025 Priority SHALL be HALT > wait > EX_Redirect > load_use > normal.
REQ-026 Normal: PC_Write=1, IF_ID_Write=1; all flushes, PipeHold = 0.
REQ-027 HALT: PC_Write=0, IF_ID_Write=0, PipeHold=1, all flushes 0.
REQ-028 Wait: PC_Write=0, IF_ID_Write=0, PipeHold=1, MEM_WB_Flush=1, other flushes 0.
REQ-029 Redirect: PC_Write=1, IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Flush=1; FlushCount +1.
REQ-030 Load-use: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1; StallCount +1; exactly one bubble per hazard.
REQ-031 Redirect with load_use same cycle: redirect behaviour only; FlushCount +1, StallCount unchanged.
REQ-032 FSM: RUN->MEM_WAIT when wait; MEM_WAIT->RUN when ~wait; MEM_WAIT->HALT when wait and wait counter == WAIT_LIMIT-1; HALT exits only by reset.
REQ-033 Wait counter (8 bits) SHALL clear in RUN, increment each MEM_WAIT cycle with wait asserted.
REQ-034 Exit cycle (MEM_Ready=1): redirect/load_use evaluated normally that cycle.
REQ-035 Timeout SHALL set on entry to HALT and stay 1 until reset.
REQ-036 Counters SHALL saturate at 16'hFFFF; clear_counters wins over same-cycle increment.
REQ-037 Redirect or load_use while wait asserted SHALL not count; counted once wait drops.

Reset
REQ-038 reset_n=0 at posedge: State=RUN, wait counter=0, Timeout=0, StallCount=0, FlushCount=0.
REQ-039 While reset_n=0, outputs SHALL be PC_Write=0, IF_ID_Write=0, PipeHold=0, IF_ID_Flush=1, ID_EX_Flush=1, MEM_WB_Flush=1.
REQ-040 Reset mid-MEM_WAIT or in HALT SHALL return to RUN next cycle.

Verification
REQ-041 lw $2 in EX (EX_MemRead=1, EX_RegisterRt=2), ID rs=2 -> PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1 for one cycle; StallCount=1.
REQ-042 EX_RegisterRt=0 with ID rs=0, EX_MemRead=1 -> no stall; ID_UsesRt=0 and rt match only -> no stall.
REQ-043 EX_Redirect=1 with load_use=1 -> IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1; FlushCount=1, StallCount=0.
REQ-044 MEM_Access=1, MEM_Ready=0 for 3 cycles then 1 -> PipeHold=1, MEM_WB_Flush=1 for 3 cycles, State 01, then RUN.
REQ-045 WAIT_LIMIT=4, MEM_Ready held 0 -> State=10, Timeout=1 after 4th MEM_WAIT cycle; stays until reset_n=0 -> State=00, Timeout=0.
REQ-046 StallCount=16'hFFFF plus load_use -> stays FFFF; clear_counters with increment -> 0.
